// File: rtl/edu_token_sched_pkg.sv
// Shared types and size derivations for the token-row scheduler.
// Holds default row count, width helpers and the FSM state type.
package edu_token_sched_pkg;

    // Default token-row count (2*NUM_AQROW-1 with four AQ rows).
    localparam int DEF_NUM_TROW = 7;

    // Row index is one bit wider than strictly needed.
    function automatic int row_w_of(input int n);
        return $clog2(n) + 1;
    endfunction

    // Counter must be able to hold n itself.
    function automatic int cnt_w_of(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DEF_ROW_W = row_w_of(DEF_NUM_TROW);
    localparam int DEF_CNT_W = cnt_w_of(DEF_NUM_TROW);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/edu_token_sched_if.sv
// Valid/ready handshake carrying one token-row index downstream.
// master: scheduler (drives valid/row/onehot); slave: consumer (drives ready).
interface edu_token_sched_if
    import edu_token_sched_pkg::*;
#(
    parameter int NUM_TROW = DEF_NUM_TROW,
    parameter int ROW_W    = row_w_of(NUM_TROW)
);
    logic                tok_valid;
    logic                tok_ready;
    logic [ROW_W-1:0]    tok_row;
    logic [NUM_TROW-1:0] tok_onehot;

    modport master (
        output tok_valid,
        output tok_row,
        output tok_onehot,
        input  tok_ready
    );

    modport slave (
        input  tok_valid,
        input  tok_row,
        input  tok_onehot,
        output tok_ready
    );
endinterface

// File: rtl/edu_token_prio_enc.sv
// Combinational lowest-set-bit finder.
// in: vec; out: exist (any bit set), index (lowest set bit), onehot.
module edu_token_prio_enc #(
    parameter int N  = 7,
    parameter int IW = 4
) (
    input  logic [N-1:0]  vec,
    output logic          exist,
    output logic [IW-1:0] index,
    output logic [N-1:0]  onehot
);

    always_comb begin
        index = '0;
        // Scan downward so the lowest set bit is the last write.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = IW'(i);
            end
        end
    end

    assign exist  = |vec;
    // Two's-complement trick isolates the lowest set bit.
    assign onehot = vec & (~vec + N'(1));

endmodule

// File: rtl/edu_token_sched.sv
// Token-row scheduler: captures a row mask on start, then offers each
// set row lowest-first over tok (valid/ready), then pulses done.
// Ports: clk, rst_n, start, abort, token_exist_in, tok (master),
// busy, done, issue_cnt.
module edu_token_sched
    import edu_token_sched_pkg::*;
#(
    parameter int NUM_TROW = DEF_NUM_TROW,
    parameter int ROW_W    = row_w_of(NUM_TROW),
    parameter int CNT_W    = cnt_w_of(NUM_TROW)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [NUM_TROW-1:0] token_exist_in,
    edu_token_sched_if.master   tok,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    issue_cnt
);

    state_t              state_q, state_d;
    logic [NUM_TROW-1:0] pending_q, pending_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                pend_exist;
    logic [ROW_W-1:0]    pend_idx;
    logic [NUM_TROW-1:0] pend_oh;
    logic                offer;

    edu_token_prio_enc #(
        .N  (NUM_TROW),
        .IW (ROW_W)
    ) u_prio (
        .vec    (pending_q),
        .exist  (pend_exist),
        .index  (pend_idx),
        .onehot (pend_oh)
    );

    assign offer = (state_q == S_ISSUE) && pend_exist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_ISSUE;
                    pending_d = token_exist_in;
                    cnt_d     = '0;
                end
            end
            S_ISSUE: begin
                if (!pend_exist) begin
                    state_d = S_DONE;
                end else if (tok.tok_ready) begin
                    pending_d = pending_q & ~pend_oh;
                    // Saturate rather than wrap.
                    if (cnt_q != CNT_W'(NUM_TROW)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                pending_d = '0;
            end
        endcase
        // Abort overrides load and any coincident handshake.
        if (abort) begin
            state_d   = S_IDLE;
            pending_d = '0;
            cnt_d     = cnt_q;
        end
    end

    always_comb begin
        tok.tok_valid  = offer;
        tok.tok_row    = offer ? pend_idx : '0;
        tok.tok_onehot = offer ? pend_oh : '0;
    end

    assign busy      = (state_q == S_ISSUE) || (state_q == S_DONE);
    assign done      = (state_q == S_DONE);
    assign issue_cnt = cnt_q;

endmodule

// File: tb/tb_edu_token_sched.sv
// Self-checking bench for edu_token_sched: directed passes plus random
// passes compared against a queue-based reference model.
module tb_edu_token_sched;

    localparam int NT = 7;
    localparam int RW = 4;
    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [NT-1:0] tex;
    logic          busy;
    logic          done;
    logic [CW-1:0] issue_cnt;

    edu_token_sched_if #(.NUM_TROW(NT), .ROW_W(RW)) tif ();

    edu_token_sched #(
        .NUM_TROW (NT),
        .ROW_W    (RW),
        .CNT_W    (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .token_exist_in (tex),
        .tok            (tif),
        .busy           (busy),
        .done           (done),
        .issue_cnt      (issue_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 idle, 1 issuing, 2 completing.
    int ph;
    int q[$];
    int cnt;

    // Observation log.
    int hs[$];
    int cyc;
    int last_hs;
    int done_cyc;
    int ndone;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph  = 0;
        q.delete();
        cnt = 0;
    endtask

    task automatic check_outputs();
        logic        ev;
        logic [31:0] er;
        logic [31:0] eo;
        ev = (ph == 1) && (q.size() > 0);
        er = ev ? 32'(q[0]) : 32'd0;
        eo = ev ? (32'd1 << q[0]) : 32'd0;
        chk("tok_valid", 32'(tif.tok_valid), 32'(ev));
        chk("tok_row", 32'(tif.tok_row), er);
        chk("tok_onehot", 32'(tif.tok_onehot), eo);
        chk("busy", 32'(busy), 32'(ph != 0));
        chk("done", 32'(done), 32'(ph == 2));
        chk("issue_cnt", 32'(issue_cnt), 32'(cnt));
    endtask

    task automatic model_step();
        if (abort) begin
            ph = 0;
            q.delete();
        end else if (ph == 0) begin
            if (start) begin
                q.delete();
                for (int i = 0; i < NT; i++) begin
                    if (tex[i]) q.push_back(i);
                end
                cnt = 0;
                ph  = 1;
            end
        end else if (ph == 1) begin
            if (q.size() == 0) begin
                ph = 2;
            end else if (tif.tok_ready) begin
                void'(q.pop_front());
                if (cnt < NT) cnt++;
            end
        end else begin
            ph = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        if (tif.tok_valid && tif.tok_ready && !abort) begin
            hs.push_back(int'(tif.tok_row));
            last_hs = cyc;
        end
        if (done) begin
            done_cyc = cyc;
            ndone++;
        end
        model_step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic run_to_idle();
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (ph == 0) break;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(tif.tok_valid), 32'd0);
        chk({tag, "_row"}, 32'(tif.tok_row), 32'd0);
        chk({tag, "_onehot"}, 32'(tif.tok_onehot), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_cnt"}, 32'(issue_cnt), 32'd0);
    endtask

    task automatic begin_pass(input logic [NT-1:0] m);
        hs.delete();
        ndone = 0;
        tex   = m;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin
        int d0;
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        tex           = '0;
        tif.tok_ready = 1'b0;
        cyc           = 0;
        last_hs       = 0;
        done_cyc      = 0;
        ndone         = 0;
        model_reset();
        #3;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three rows back-to-back.
        tif.tok_ready = 1'b1;
        begin_pass(7'b0010110);
        run_to_idle();
        chk("p1_nhs", 32'(hs.size()), 32'd3);
        if (hs.size() == 3) begin
            chk("p1_row0", 32'(hs[0]), 32'd1);
            chk("p1_row1", 32'(hs[1]), 32'd2);
            chk("p1_row2", 32'(hs[2]), 32'd4);
        end
        chk("p1_done_lat", 32'(done_cyc - last_hs), 32'd2);
        chk("p1_ndone", 32'(ndone), 32'd1);
        chk("p1_cnt", 32'(issue_cnt), 32'd3);

        // Stall with ready low, offer must hold.
        tif.tok_ready = 1'b0;
        begin_pass(7'b1000001);
        for (int k = 0; k < 3; k++) begin
            chk("p2_hold_row", 32'(tif.tok_row), 32'd0);
            chk("p2_hold_oh", 32'(tif.tok_onehot), 32'd1);
            cycle();
        end
        tif.tok_ready = 1'b1;
        run_to_idle();
        chk("p2_nhs", 32'(hs.size()), 32'd2);
        if (hs.size() == 2) begin
            chk("p2_row0", 32'(hs[0]), 32'd0);
            chk("p2_row1", 32'(hs[1]), 32'd6);
        end
        chk("p2_cnt", 32'(issue_cnt), 32'd2);

        // Empty load; start held through ISSUE and DONE is ignored.
        d0 = cyc;
        hs.delete();
        ndone = 0;
        tex   = '0;
        start = 1'b1;
        cycle();
        cycle();
        cycle();
        start = 1'b0;
        cycle();
        chk("p3_nhs", 32'(hs.size()), 32'd0);
        chk("p3_ndone", 32'(ndone), 32'd1);
        chk("p3_done_at", 32'(done_cyc - d0), 32'd2);
        chk("p3_cnt", 32'(issue_cnt), 32'd0);
        chk("p3_idle", 32'(busy), 32'd0);

        // Abort coincident with the third handshake.
        begin_pass(7'b1111111);
        cycle();
        cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        cycle();
        cycle();
        chk("p4_nhs", 32'(hs.size()), 32'd2);
        chk("p4_ndone", 32'(ndone), 32'd0);
        chk("p4_cnt", 32'(issue_cnt), 32'd2);
        chk("p4_busy", 32'(busy), 32'd0);
        chk("p4_valid", 32'(tif.tok_valid), 32'd0);

        // Reset mid-pass after one handshake, stray start ignored.
        begin_pass(7'b0110000);
        start = 1'b1;
        cycle();
        chk("p5_row", 32'(tif.tok_row), 32'd5);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0;
        cycle();
        cycle();
        chk("p5_ndone", 32'(ndone), 32'd0);

        // Random passes.
        for (int p = 0; p < 60; p++) begin
            begin_pass(NT'($urandom));
            for (int k = 0; k < 30; k++) begin
                tif.tok_ready = ($urandom_range(0, 3) != 0);
                abort         = ($urandom_range(0, 29) == 0);
                start         = ($urandom_range(0, 4) == 0) && (ph != 0);
                cycle();
                if (ph == 0) break;
            end
            abort = 1'b0;
            start = 1'b0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
